kitchen_timer_mc: RTL and testbench

Multi-channel, parametrised kitchen-timer core: CHANNELS independent mm:ss timers, each loadable from a 6-bit number, counting up or down at normal or fast rate, with pause/resume and a per-channel done LED. A channel-select input routes the load, start and pause commands to one channel and drives the BCD display outputs from that channel. It is the successor to the single-channel timer FSM and feeds the same seven-segment display driver.

---
 rtl/kitchen_timer_mc.sv | 250 +++++++++++++++++++++++++
 tb/tb_kitchen_timer_mc.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kitchen_timer_mc.sv
// rtl/kitchen_timer_mc.sv - multi-channel mm:ss kitchen timer core with registered BCD readout
//
// CHANNELS independent timers, each loaded from a clamped 6-bit value and counting
// up (00:00 -> target) or down (target -> 00:00) at a normal or fast rate.
//
// Ports:
//   clock, reset     : single clock domain, synchronous active-high reset
//   num              : load value, values above 59 clamp to 59
//   ch_sel           : channel addressed by commands and shown on the display
//   get_min, get_sec : load target minutes / seconds (rising-edge detected)
//   start            : start the selected channel (rising-edge detected)
//   pause            : toggle pause/resume on the selected channel (rising-edge detected)
//   up               : direction captured at start, 1 = count up
//   fast             : rate for every running channel, 1 = FAST_DIV cycles per second
//   led              : per-channel done indicator
//   min_1..sec_0     : registered BCD digits of the selected channel's count

module kitchen_timer_mc #(
    parameter int CHANNELS = 4,
    parameter int TICK_DIV = 100,
    parameter int FAST_DIV = 1,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          num,
    input  logic [SEL_W-1:0]    ch_sel,
    input  logic                get_min,
    input  logic                get_sec,
    input  logic                start,
    input  logic                pause,
    input  logic                up,
    input  logic                fast,
    output logic [CHANNELS-1:0] led,
    output logic [3:0]          min_1,
    output logic [3:0]          min_0,
    output logic [3:0]          sec_1,
    output logic [3:0]          sec_0
);

    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   FAST_LAST = PW'(FAST_DIV - 1);
    localparam logic [SEL_W:0]  CH_LIM    = (SEL_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Previous samples of {get_min, get_sec, start, pause}; tracked through reset
    // so an input held high across reset release does not produce an event.
    logic [3:0]          cmd_prev_q, cmd_prev_d;
    logic                ev_min, ev_sec, ev_start, ev_pause;
    logic [5:0]          num_sat;
    logic [PW-1:0]       last_presc;
    logic [CHANNELS-1:0] sel_hit;
    logic [CHANNELS-1:0] ld_hit, start_hit, pause_hit;

    state_t              st_q      [CHANNELS];
    state_t              st_d      [CHANNELS];
    logic [5:0]          tgt_min_q [CHANNELS];
    logic [5:0]          tgt_min_d [CHANNELS];
    logic [5:0]          tgt_sec_q [CHANNELS];
    logic [5:0]          tgt_sec_d [CHANNELS];
    logic [5:0]          cnt_min_q [CHANNELS];
    logic [5:0]          cnt_min_d [CHANNELS];
    logic [5:0]          cnt_sec_q [CHANNELS];
    logic [5:0]          cnt_sec_d [CHANNELS];
    logic [PW-1:0]       presc_q   [CHANNELS];
    logic [PW-1:0]       presc_d   [CHANNELS];
    logic [CHANNELS-1:0] dir_q, dir_d;
    logic [CHANNELS-1:0] led_q, led_d;

    logic [5:0]          disp_min, disp_sec;
    logic [3:0]          min_1_q, min_1_d, min_0_q, min_0_d;
    logic [3:0]          sec_1_q, sec_1_d, sec_0_q, sec_0_d;

    // Count has reached its end point for the latched direction.
    function automatic logic at_end(input logic d, input logic [5:0] m, input logic [5:0] s,
                                    input logic [5:0] tm, input logic [5:0] ts);
        return d ? ((m == tm) && (s == ts)) : ((m == 6'd0) && (s == 6'd0));
    endfunction

    // 0..59 to two BCD digits. The units digit only needs the low nibble because
    // v - 10*tens is below 10, so the subtraction is done modulo 16.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [3:0] sub;
        if (v >= 6'd50) begin
            t = 4'd5; sub = 4'd2;
        end else if (v >= 6'd40) begin
            t = 4'd4; sub = 4'd8;
        end else if (v >= 6'd30) begin
            t = 4'd3; sub = 4'd14;
        end else if (v >= 6'd20) begin
            t = 4'd2; sub = 4'd4;
        end else if (v >= 6'd10) begin
            t = 4'd1; sub = 4'd10;
        end else begin
            t = 4'd0; sub = 4'd0;
        end
        return {t, v[3:0] - sub};
    endfunction

    // Command decode: one event per rising input, routed to the selected channel.
    // A load event masks start and pause; start masks pause.
    always_comb begin
        cmd_prev_d = {get_min, get_sec, start, pause};
        ev_min     = get_min & ~cmd_prev_q[3];
        ev_sec     = get_sec & ~cmd_prev_q[2];
        ev_start   = start   & ~cmd_prev_q[1];
        ev_pause   = pause   & ~cmd_prev_q[0];
        num_sat    = (num > 6'd59) ? 6'd59 : num;
        last_presc = fast ? FAST_LAST : TICK_LAST;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_hit[i]   = ({1'b0, ch_sel} < CH_LIM) && (ch_sel == SEL_W'(i));
            ld_hit[i]    = sel_hit[i] & (ev_min | ev_sec);
            start_hit[i] = sel_hit[i] & ev_start & ~ld_hit[i];
            pause_hit[i] = sel_hit[i] & ev_pause & ~ev_start & ~ld_hit[i];
        end
    end

    // Per-channel next state.
    always_comb begin
        dir_d = dir_q;
        led_d = led_q;
        for (int i = 0; i < CHANNELS; i++) begin
            st_d[i]      = st_q[i];
            tgt_min_d[i] = tgt_min_q[i];
            tgt_sec_d[i] = tgt_sec_q[i];
            cnt_min_d[i] = cnt_min_q[i];
            cnt_sec_d[i] = cnt_sec_q[i];
            presc_d[i]   = presc_q[i];

            if (ld_hit[i] && (st_q[i] == ST_IDLE || st_q[i] == ST_DONE)) begin
                if (ev_min) tgt_min_d[i] = num_sat;
                if (ev_sec) tgt_sec_d[i] = num_sat;
                cnt_min_d[i] = tgt_min_d[i];
                cnt_sec_d[i] = tgt_sec_d[i];
                led_d[i]     = 1'b0;
                st_d[i]      = ST_IDLE;
            end else if (start_hit[i] && (st_q[i] == ST_IDLE || st_q[i] == ST_DONE)) begin
                dir_d[i]     = up;
                presc_d[i]   = '0;
                led_d[i]     = 1'b0;
                cnt_min_d[i] = up ? 6'd0 : tgt_min_q[i];
                cnt_sec_d[i] = up ? 6'd0 : tgt_sec_q[i];
                st_d[i]      = ST_RUN;
            end else if (st_q[i] == ST_RUN) begin
                // A channel started already at its end point (zero target)
                // finishes on the first running edge without ticking.
                if (at_end(dir_q[i], cnt_min_q[i], cnt_sec_q[i], tgt_min_q[i], tgt_sec_q[i])) begin
                    st_d[i]  = ST_DONE;
                    led_d[i] = 1'b1;
                end else begin
                    // >= rather than == so a switch to the fast rate mid-second
                    // ticks immediately instead of wrapping the prescaler.
                    if (presc_q[i] >= last_presc) begin
                        presc_d[i] = '0;
                        if (dir_q[i]) begin
                            if (cnt_sec_q[i] == 6'd59) begin
                                cnt_sec_d[i] = 6'd0;
                                cnt_min_d[i] = cnt_min_q[i] + 6'd1;
                            end else begin
                                cnt_sec_d[i] = cnt_sec_q[i] + 6'd1;
                            end
                        end else begin
                            if (cnt_sec_q[i] == 6'd0) begin
                                cnt_sec_d[i] = 6'd59;
                                cnt_min_d[i] = cnt_min_q[i] - 6'd1;
                            end else begin
                                cnt_sec_d[i] = cnt_sec_q[i] - 6'd1;
                            end
                        end
                    end else begin
                        presc_d[i] = presc_q[i] + PW'(1);
                    end
                    // Completion wins over a pause arriving on the same edge.
                    if (at_end(dir_q[i], cnt_min_d[i], cnt_sec_d[i], tgt_min_q[i], tgt_sec_q[i])) begin
                        st_d[i]  = ST_DONE;
                        led_d[i] = 1'b1;
                    end else if (pause_hit[i]) begin
                        st_d[i] = ST_PAUSED;
                    end
                end
            end else if (st_q[i] == ST_PAUSED && pause_hit[i]) begin
                st_d[i] = ST_RUN;
            end
        end
    end

    // Display mux: out-of-range selection shows 00:00.
    always_comb begin
        disp_min = 6'd0;
        disp_sec = 6'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_hit[i]) begin
                disp_min = cnt_min_q[i];
                disp_sec = cnt_sec_q[i];
            end
        end
        {min_1_d, min_0_d} = to_bcd(disp_min);
        {sec_1_d, sec_0_d} = to_bcd(disp_sec);
    end

    always_ff @(posedge clock) begin
        cmd_prev_q <= cmd_prev_d;
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]      <= ST_IDLE;
                tgt_min_q[i] <= '0;
                tgt_sec_q[i] <= '0;
                cnt_min_q[i] <= '0;
                cnt_sec_q[i] <= '0;
                presc_q[i]   <= '0;
            end
            dir_q   <= '0;
            led_q   <= '0;
            min_1_q <= '0;
            min_0_q <= '0;
            sec_1_q <= '0;
            sec_0_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]      <= st_d[i];
                tgt_min_q[i] <= tgt_min_d[i];
                tgt_sec_q[i] <= tgt_sec_d[i];
                cnt_min_q[i] <= cnt_min_d[i];
                cnt_sec_q[i] <= cnt_sec_d[i];
                presc_q[i]   <= presc_d[i];
            end
            dir_q   <= dir_d;
            led_q   <= led_d;
            min_1_q <= min_1_d;
            min_0_q <= min_0_d;
            sec_1_q <= sec_1_d;
            sec_0_q <= sec_0_d;
        end
    end

    assign led   = led_q;
    assign min_1 = min_1_q;
    assign min_0 = min_0_q;
    assign sec_1 = sec_1_q;
    assign sec_0 = sec_0_q;

endmodule

// File: tb/tb_kitchen_timer_mc.sv
// tb/tb_kitchen_timer_mc.sv - directed and randomized bench for kitchen_timer_mc against a seconds-based model

module tb_kitchen_timer_mc;

    localparam int CH = 2;
    localparam int TD = 4;
    localparam int FD = 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [5:0]    num;
    logic [0:0]    ch_sel;
    logic          get_min, get_sec, start, pause, up, fast;
    logic [CH-1:0] led;
    logic [3:0]    min_1, min_0, sec_1, sec_0;

    always #5 clock = ~clock;

    kitchen_timer_mc #(.CHANNELS(CH), .TICK_DIV(TD), .FAST_DIV(FD)) dut (
        .clock   (clock),
        .reset   (reset),
        .num     (num),
        .ch_sel  (ch_sel),
        .get_min (get_min),
        .get_sec (get_sec),
        .start   (start),
        .pause   (pause),
        .up      (up),
        .fast    (fast),
        .led     (led),
        .min_1   (min_1),
        .min_0   (min_0),
        .sec_1   (sec_1),
        .sec_0   (sec_0)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: counts kept as total seconds.
    int          m_tmin [CH];
    int          m_tsec [CH];
    int          m_cnt  [CH];
    int          m_phase[CH];
    bit          m_up    [CH];
    bit          m_active[CH];
    bit          m_paused[CH];
    bit          m_led   [CH];
    bit          p_min = 0, p_sec = 0, p_start = 0, p_pause = 0;
    logic [15:0] m_disp = 16'h0;

    function automatic logic [15:0] bcd16(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit e_min, e_sec, e_start, e_pause, hit, ld, stt, pz;
        int goal, sat, lastp;
        e_min   = get_min && !p_min;
        e_sec   = get_sec && !p_sec;
        e_start = start && !p_start;
        e_pause = pause && !p_pause;
        p_min = get_min; p_sec = get_sec; p_start = start; p_pause = pause;
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                m_tmin[c] = 0; m_tsec[c] = 0; m_cnt[c] = 0; m_phase[c] = 0;
                m_up[c] = 0; m_active[c] = 0; m_paused[c] = 0; m_led[c] = 0;
            end
            m_disp = 16'h0;
            return;
        end
        m_disp = (int'(ch_sel) < CH) ? bcd16(m_cnt[ch_sel]) : 16'h0;
        sat   = (num > 59) ? 59 : int'(num);
        lastp = fast ? FD - 1 : TD - 1;
        for (int c = 0; c < CH; c++) begin
            hit  = (int'(ch_sel) == c);
            ld   = hit && (e_min || e_sec);
            stt  = hit && e_start && !ld;
            pz   = hit && e_pause && !ld && !e_start;
            goal = m_up[c] ? m_tmin[c] * 60 + m_tsec[c] : 0;
            if (!m_active[c]) begin
                if (ld) begin
                    if (e_min) m_tmin[c] = sat;
                    if (e_sec) m_tsec[c] = sat;
                    m_cnt[c] = m_tmin[c] * 60 + m_tsec[c];
                    m_led[c] = 0;
                end else if (stt) begin
                    m_up[c]     = up;
                    m_phase[c]  = 0;
                    m_led[c]    = 0;
                    m_cnt[c]    = up ? 0 : m_tmin[c] * 60 + m_tsec[c];
                    m_active[c] = 1;
                    m_paused[c] = 0;
                end
            end else if (m_paused[c]) begin
                if (pz) m_paused[c] = 0;
            end else if (m_cnt[c] == goal) begin
                m_active[c] = 0;
                m_led[c]    = 1;
            end else begin
                if (m_phase[c] >= lastp) begin
                    m_phase[c] = 0;
                    m_cnt[c]   = m_cnt[c] + (m_up[c] ? 1 : -1);
                end else begin
                    m_phase[c]++;
                end
                if (m_cnt[c] == goal) begin
                    m_active[c] = 0;
                    m_led[c]    = 1;
                end else if (pz) begin
                    m_paused[c] = 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("led", {30'b0, led}, {30'b0, m_led[1], m_led[0]});
        check("disp", {16'b0, min_1, min_0, sec_1, sec_0}, {16'b0, m_disp});
    endtask

    task automatic wait_led(input int c, input int limit, output int n);
        n = 0;
        while (led[c] !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n, t0, t1;
        reset = 1; num = 0; ch_sel = 0; get_min = 0; get_sec = 0;
        start = 0; pause = 0; up = 0; fast = 0;

        // Reset state
        step(); step();
        check("rst_led", {30'b0, led}, 32'h0);
        check("rst_disp", {16'b0, min_1, min_0, sec_1, sec_0}, 32'h0);
        reset = 0;
        step();

        // Down count from 01:00 at normal rate
        ch_sel = 0; num = 1; get_min = 1; step(); get_min = 0;
        up = 0; start = 1; step(); start = 0;
        repeat (4) step();
        check("t1_disp_0100", {16'b0, min_1, min_0, sec_1, sec_0}, 32'h0100);
        step();
        check("t1_disp_0059", {16'b0, min_1, min_0, sec_1, sec_0}, 32'h0059);
        wait_led(0, 300, n);
        check("t1_led_cycle", n + 5, 240);

        // Up count to 00:03 at fast rate
        fast = 1;
        num = 0; get_min = 1; step(); get_min = 0;
        num = 3; get_sec = 1; step(); get_sec = 0;
        up = 1; start = 1; step(); start = 0;
        step(); step();
        check("t2_disp_0001", {16'b0, min_1, min_0, sec_1, sec_0}, 32'h0001);
        step();
        check("t2_disp_0002", {16'b0, min_1, min_0, sec_1, sec_0}, 32'h0002);
        check("t2_led", {31'b0, led[0]}, 32'h1);
        step(); step(); step();
        check("t2_hold", {16'b0, min_1, min_0, sec_1, sec_0}, 32'h0003);
        fast = 0;

        // Pause and resume on a down count from 00:05
        num = 0; get_min = 1; step(); get_min = 0;
        num = 5; get_sec = 1; step(); get_sec = 0;
        up = 0; start = 1; step(); start = 0;
        repeat (5) step();
        pause = 1; step(); pause = 0;
        for (int k = 0; k < 19; k++) begin
            step();
            check("t3_frozen", {16'b0, min_1, min_0, sec_1, sec_0}, 32'h0004);
        end
        pause = 1; step(); pause = 0;
        wait_led(0, 60, n);
        check("t3_led_cycle", 26 + n, 40);

        // Two channels running independently
        ch_sel = 0; num = 0; get_min = 1; step(); get_min = 0;
        num = 2; get_sec = 1; step(); get_sec = 0;
        ch_sel = 1; num = 0; get_min = 1; step(); get_min = 0;
        num = 3; get_sec = 1; step(); get_sec = 0;
        ch_sel = 0; up = 0; start = 1; step(); start = 0;
        ch_sel = 1; up = 1; step();
        start = 1; step(); start = 0;
        t0 = -1; t1 = -1;
        for (int k = 3; k < 23; k++) begin
            ch_sel = ~ch_sel;
            step();
            if (led[0] === 1'b1 && t0 < 0) t0 = k;
            if (led[1] === 1'b1 && t1 < 0) t1 = k;
        end
        check("t4_led0_cycle", t0, 8);
        check("t4_led1_cycle", t1, 14);

        // Clamp, ignored load while running, start+pause together
        ch_sel = 0; num = 0; get_min = 1; step(); get_min = 0;
        num = 63; get_sec = 1; step(); get_sec = 0;
        step();
        check("t5_clamp", {16'b0, min_1, min_0, sec_1, sec_0}, 32'h0059);
        up = 0; start = 1; step(); start = 0;
        repeat (6) step();
        num = 5; get_min = 1; step(); get_min = 0;
        step();
        check("t5_ld_ignored", {16'b0, min_1, min_0, sec_1, sec_0}, 32'h0058);
        ch_sel = 1; num = 0; get_min = 1; step(); get_min = 0;
        num = 10; get_sec = 1; step(); get_sec = 0;
        up = 0; start = 1; pause = 1; step(); start = 0; pause = 0;
        repeat (5) step();
        check("t5_start_wins", {16'b0, min_1, min_0, sec_1, sec_0}, 32'h0009);

        // Reset mid-count, then zero-target start
        reset = 1; step(); reset = 0;
        check("t6_rst_led", {30'b0, led}, 32'h0);
        check("t6_rst_disp", {16'b0, min_1, min_0, sec_1, sec_0}, 32'h0);
        ch_sel = 0; up = 0; start = 1; step(); start = 0;
        step();
        check("t6_zero_done", {31'b0, led[0]}, 32'h1);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            reset   = ($urandom_range(0, 299) == 0);
            get_min = ($urandom_range(0, 39) == 0);
            get_sec = ($urandom_range(0, 29) == 0);
            start   = ($urandom_range(0, 14) == 0);
            pause   = ($urandom_range(0, 19) == 0);
            num     = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
            ch_sel  = 1'($urandom_range(0, 1));
            up      = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) fast = ~fast;
            step();
        end

        reset = 0; get_min = 0; get_sec = 0; start = 0; pause = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
